adr_seq_ctrl: RTL and testbench

ADR_SEQ_CTRL -- requirements
Module: adr_seq_ctrl

---
 rtl/adr_seq_ctrl.sv | 254 +++++++++++++++++++++++++
 tb/tb_adr_seq_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adr_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : adr_seq_ctrl
// Description : Sequencer for the matrix address maker. Runs two job types:
//               - direct load: writes an 18-bit address into the address
//                 maker in three byte-wide steps (last8, mid8, first2);
//               - downsample scan: for each of 4 quads, reads every (r,c)
//                 with r,c even (r+1<dim, c+1<dim) and writes the result
//                 to (r/2, c/2), handshaking each access on mem_req/mem_ack.
//               All outputs are registered.
// Ports       : in_Clock, in_Reset_n (sync, active-low)
//               start_scan, start_load, dim[7:0], load_addr[17:0]  - job control
//               mem_ack / mem_req, mem_we                          - memory handshake
//               ART, ARG, AWT, AWG, A, SEL, TOG_inc, QUAD_inc      - to address maker
//               busy, done, quad[1:0]                              - status
// Config      : define ADR_SEQ_TRANSPOSE_EN to pulse TOG_inc together with
//               QUAD_inc; otherwise TOG_inc is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module adr_seq_ctrl #(
    parameter logic [2:0] SEL_IDLE = 3'd7
) (
    input  logic        in_Clock,
    input  logic        in_Reset_n,
    input  logic        start_scan,
    input  logic        start_load,
    input  logic [7:0]  dim,
    input  logic [17:0] load_addr,
    input  logic        mem_ack,
    output logic [7:0]  ART,
    output logic [7:0]  ARG,
    output logic [7:0]  AWT,
    output logic [7:0]  AWG,
    output logic [7:0]  A,
    output logic [2:0]  SEL,
    output logic        TOG_inc,
    output logic        QUAD_inc,
    output logic        mem_req,
    output logic        mem_we,
    output logic        busy,
    output logic        done,
    output logic [1:0]  quad
);

    // Address maker SEL codes
    localparam logic [2:0] c_ADR_MATRIX_R = 3'd0;
    localparam logic [2:0] c_ADR_MATRIX_W = 3'd1;
    localparam logic [2:0] c_ADR_LAST8    = 3'd2;
    localparam logic [2:0] c_ADR_MID8     = 3'd3;
    localparam logic [2:0] c_ADR_FIRST2   = 3'd4;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_LD_L   = 4'd1,
        ST_LD_M   = 4'd2,
        ST_LD_F   = 4'd3,
        ST_RD_SET = 4'd4,
        ST_RD_REQ = 4'd5,
        ST_WR_SET = 4'd6,
        ST_WR_REQ = 4'd7,
        ST_ADV    = 4'd8,
        ST_QADV   = 4'd9,
        ST_FIN    = 4'd10
    } state_t;

    state_t      r_state;
    logic [7:0]  r_dim;
    logic [17:0] r_addr;
    logic [7:0]  r_row;
    logic [7:0]  r_col;
    logic [7:0]  r_art, r_arg, r_awt, r_awg, r_a;
    logic [2:0]  r_sel;
    logic        r_quad_inc, r_mem_req, r_mem_we, r_busy, r_done;
    logic [1:0]  r_quad;

    // Candidate next row/column. A step is kept only if the new index still
    // has a partner (idx+1 < dim); this drops the trailing row/column of an
    // odd matrix and sends dim<2 straight through to the quad advance.
    logic [8:0]  w_col_nxt, w_row_nxt;
    logic        w_col_wrap, w_row_wrap;

    assign w_col_nxt  = {1'b0, r_col} + 9'd2;
    assign w_row_nxt  = {1'b0, r_row} + 9'd2;
    assign w_col_wrap = (w_col_nxt + 9'd1) >= {1'b0, r_dim};
    assign w_row_wrap = (w_row_nxt + 9'd1) >= {1'b0, r_dim};

    always_ff @(posedge in_Clock) begin
        if (!in_Reset_n) begin
            r_state    <= ST_IDLE;
            r_dim      <= 8'd0;
            r_addr     <= 18'd0;
            r_row      <= 8'd0;
            r_col      <= 8'd0;
            r_art      <= 8'd0;
            r_arg      <= 8'd0;
            r_awt      <= 8'd0;
            r_awg      <= 8'd0;
            r_a        <= 8'd0;
            r_sel      <= SEL_IDLE;
            r_quad_inc <= 1'b0;
            r_mem_req  <= 1'b0;
            r_mem_we   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_quad     <= 2'd0;
        end else begin
            r_quad_inc <= 1'b0;
            r_done     <= 1'b0;
            // Outputs are assigned on the transition into each state so they
            // are valid for the whole time the state is occupied.
            case (r_state)
                ST_IDLE: begin
                    r_sel <= SEL_IDLE;
                    if (start_scan) begin
                        r_dim  <= dim;
                        r_row  <= 8'd0;
                        r_col  <= 8'd0;
                        r_busy <= 1'b1;
                        if (dim < 8'd2) begin
                            r_state <= ST_ADV;
                        end else begin
                            r_state <= ST_RD_SET;
                            r_sel   <= c_ADR_MATRIX_R;
                            r_art   <= 8'd0;
                            r_arg   <= 8'd0;
                        end
                    end else if (start_load) begin
                        r_addr  <= load_addr;
                        r_busy  <= 1'b1;
                        r_state <= ST_LD_L;
                        r_sel   <= c_ADR_LAST8;
                        r_a     <= load_addr[7:0];
                    end
                end
                ST_LD_L: begin
                    r_state <= ST_LD_M;
                    r_sel   <= c_ADR_MID8;
                    r_a     <= r_addr[15:8];
                end
                ST_LD_M: begin
                    r_state <= ST_LD_F;
                    r_sel   <= c_ADR_FIRST2;
                    r_a     <= {6'b0, r_addr[17:16]};
                end
                ST_LD_F: begin
                    r_state <= ST_FIN;
                    r_sel   <= SEL_IDLE;
                    r_done  <= 1'b1;
                end
                ST_RD_SET: begin
                    r_state   <= ST_RD_REQ;
                    r_sel     <= SEL_IDLE;
                    r_mem_req <= 1'b1;
                    r_mem_we  <= 1'b0;
                end
                ST_RD_REQ: begin
                    if (mem_ack) begin
                        r_state   <= ST_WR_SET;
                        r_mem_req <= 1'b0;
                        r_sel     <= c_ADR_MATRIX_W;
                        r_awt     <= r_row >> 1;
                        r_awg     <= r_col >> 1;
                    end
                end
                ST_WR_SET: begin
                    r_state   <= ST_WR_REQ;
                    r_sel     <= SEL_IDLE;
                    r_mem_req <= 1'b1;
                    r_mem_we  <= 1'b1;
                end
                ST_WR_REQ: begin
                    if (mem_ack) begin
                        r_state   <= ST_ADV;
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                    end
                end
                ST_ADV: begin
                    if (w_col_wrap) begin
                        r_col <= 8'd0;
                        if (w_row_wrap) begin
                            r_state    <= ST_QADV;
                            r_quad_inc <= 1'b1;
                        end else begin
                            r_row   <= w_row_nxt[7:0];
                            r_state <= ST_RD_SET;
                            r_sel   <= c_ADR_MATRIX_R;
                            r_art   <= w_row_nxt[7:0];
                            r_arg   <= 8'd0;
                        end
                    end else begin
                        r_col   <= w_col_nxt[7:0];
                        r_state <= ST_RD_SET;
                        r_sel   <= c_ADR_MATRIX_R;
                        r_art   <= r_row;
                        r_arg   <= w_col_nxt[7:0];
                    end
                end
                ST_QADV: begin
                    r_quad <= r_quad + 2'd1;
                    r_row  <= 8'd0;
                    r_col  <= 8'd0;
                    if (r_quad == 2'd3) begin
                        r_state <= ST_FIN;
                        r_done  <= 1'b1;
                    end else if (r_dim < 8'd2) begin
                        // Route through ADV so each QUAD_inc stays a
                        // separate single-cycle pulse.
                        r_state <= ST_ADV;
                    end else begin
                        r_state <= ST_RD_SET;
                        r_sel   <= c_ADR_MATRIX_R;
                        r_art   <= 8'd0;
                        r_arg   <= 8'd0;
                    end
                end
                ST_FIN: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_sel   <= SEL_IDLE;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_busy    <= 1'b0;
                    r_mem_req <= 1'b0;
                    r_mem_we  <= 1'b0;
                    r_sel     <= SEL_IDLE;
                end
            endcase
        end
    end

    assign ART      = r_art;
    assign ARG      = r_arg;
    assign AWT      = r_awt;
    assign AWG      = r_awg;
    assign A        = r_a;
    assign SEL      = r_sel;
    assign QUAD_inc = r_quad_inc;
    assign mem_req  = r_mem_req;
    assign mem_we   = r_mem_we;
    assign busy     = r_busy;
    assign done     = r_done;
    assign quad     = r_quad;

`ifdef ADR_SEQ_TRANSPOSE_EN
    // One transpose toggle per quad: four per job restore orientation.
    assign TOG_inc = r_quad_inc;
`else
    assign TOG_inc = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_adr_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_adr_seq_ctrl
// Description : Self-checking bench for adr_seq_ctrl. Expected address-maker
//               transactions are queued when a job is started and popped as
//               the DUT presents them; a memory responder acks requests.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adr_seq_ctrl;

    localparam logic [2:0] c_SEL_IDLE = 3'd7;
    localparam logic [2:0] c_MR = 3'd0;
    localparam logic [2:0] c_MW = 3'd1;
    localparam logic [2:0] c_L8 = 3'd2;
    localparam logic [2:0] c_M8 = 3'd3;
    localparam logic [2:0] c_F2 = 3'd4;
`ifdef ADR_SEQ_TRANSPOSE_EN
    localparam logic c_TOG = 1'b1;
`else
    localparam logic c_TOG = 1'b0;
`endif

    logic        in_Clock = 1'b0;
    logic        in_Reset_n = 1'b0;
    logic        start_scan = 1'b0;
    logic        start_load = 1'b0;
    logic [7:0]  dim = 8'd0;
    logic [17:0] load_addr = 18'd0;
    logic        mem_ack = 1'b0;
    logic [7:0]  ART, ARG, AWT, AWG, A;
    logic [2:0]  SEL;
    logic        TOG_inc, QUAD_inc, mem_req, mem_we, busy, done;
    logic [1:0]  quad;

    adr_seq_ctrl #(.SEL_IDLE(c_SEL_IDLE)) dut (
        .in_Clock(in_Clock), .in_Reset_n(in_Reset_n),
        .start_scan(start_scan), .start_load(start_load),
        .dim(dim), .load_addr(load_addr), .mem_ack(mem_ack),
        .ART(ART), .ARG(ARG), .AWT(AWT), .AWG(AWG), .A(A), .SEL(SEL),
        .TOG_inc(TOG_inc), .QUAD_inc(QUAD_inc),
        .mem_req(mem_req), .mem_we(mem_we), .busy(busy), .done(done), .quad(quad)
    );

    always #5 in_Clock = ~in_Clock;

    int checks = 0;
    int errors = 0;
    int n_req = 0, n_qinc = 0, n_tog = 0, n_done = 0;
    logic prev_req = 1'b0;
    logic last_we = 1'b0;
    logic ack_rand = 1'b0;
    int   ack_fix = 1;
    logic resp_abort = 1'b0;
    logic [18:0] sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the address maker is being driven.
    always @(negedge in_Clock) begin
        if (in_Reset_n) begin
            if (mem_req && !prev_req) n_req++;
            if (mem_req) begin
                chk("sel_during_req", SEL, c_SEL_IDLE);
                chk("mem_we", mem_we, last_we);
            end
            if (QUAD_inc) n_qinc++;
            if (TOG_inc) n_tog++;
            if (QUAD_inc || TOG_inc) chk("tog_inc", TOG_inc, QUAD_inc & c_TOG);
            if (done) n_done++;
            if (SEL inside {c_MR, c_MW, c_L8, c_M8, c_F2}) begin
                if (sb.size() == 0) begin
                    chk("sb_empty", 32'(sb.size()), 1);
                end else begin
                    logic [18:0] e;
                    logic [18:0] o;
                    e = sb.pop_front();
                    if (SEL == c_MR)      o = {SEL, ART, ARG};
                    else if (SEL == c_MW) o = {SEL, AWT, AWG};
                    else                  o = {SEL, A, 8'h00};
                    chk("sb_item", o, e);
                    if (SEL == c_MR) last_we = 1'b0;
                    if (SEL == c_MW) last_we = 1'b1;
                end
            end
        end
        prev_req = mem_req;
    end

    // Memory responder: ack after a fixed or random delay, one cycle wide.
    always begin
        @(negedge in_Clock);
        if (mem_req === 1'b1) begin
            int d;
            d = ack_rand ? int'($urandom_range(0, 7)) : ack_fix;
            repeat (d) @(negedge in_Clock);
            if (!resp_abort) chk("req_held", mem_req, 1);
            mem_ack = 1'b1;
            @(negedge in_Clock);
            mem_ack = 1'b0;
            if (!resp_abort) chk("req_drop", mem_req, 0);
        end
    end

    task automatic push_scan(input logic [7:0] d);
        for (int q = 0; q < 4; q++)
            for (int r = 0; r + 1 < int'(d); r += 2)
                for (int c = 0; c + 1 < int'(d); c += 2) begin
                    sb.push_back({c_MR, 8'(r), 8'(c)});
                    sb.push_back({c_MW, 8'(r / 2), 8'(c / 2)});
                end
    endtask

    task automatic kick_scan(input logic [7:0] d, input logic both);
        dim        = d;
        start_scan = 1'b1;
        start_load = both;
        load_addr  = 18'h3FFFF;
        @(negedge in_Clock);
        start_scan = 1'b0;
        start_load = 1'b0;
    endtask

    task automatic run_scan(input logic [7:0] d, input logic both);
        int d0, q0, r0, t0, np;
        np = (int'(d) / 2) * (int'(d) / 2);
        d0 = n_done; q0 = n_qinc; r0 = n_req; t0 = n_tog;
        push_scan(d);
        kick_scan(d, both);
        for (int i = 0; i < 5000 && n_done == d0; i++) @(negedge in_Clock);
        repeat (3) @(negedge in_Clock);
        chk("scan_done_cnt", n_done - d0, 1);
        chk("scan_quad_inc", n_qinc - q0, 4);
        chk("scan_tog_inc", n_tog - t0, c_TOG ? 4 : 0);
        chk("scan_req_cnt", n_req - r0, 8 * np);
        chk("scan_sb_left", sb.size(), 0);
        chk("scan_quad_end", quad, 0);
        chk("scan_busy_end", busy, 0);
        sb.delete();
    endtask

    task automatic run_load(input logic [17:0] addr);
        int d0, r0;
        d0 = n_done; r0 = n_req;
        sb.push_back({c_L8, addr[7:0], 8'h00});
        sb.push_back({c_M8, addr[15:8], 8'h00});
        sb.push_back({c_F2, 6'b0, addr[17:16], 8'h00});
        load_addr  = addr;
        start_load = 1'b1;
        @(negedge in_Clock);
        start_load = 1'b0;
        chk("ld_sel_last8", SEL, c_L8);
        @(negedge in_Clock);
        chk("ld_sel_mid8", SEL, c_M8);
        @(negedge in_Clock);
        chk("ld_sel_first2", SEL, c_F2);
        @(negedge in_Clock);
        chk("ld_done", done, 1);
        chk("ld_fin_sel", SEL, c_SEL_IDLE);
        // A start in FIN must be ignored.
        start_scan = 1'b1;
        dim = 8'd4;
        @(negedge in_Clock);
        start_scan = 1'b0;
        chk("ld_idle_after", busy, 0);
        repeat (2) @(negedge in_Clock);
        chk("ld_busy_stays0", busy, 0);
        chk("ld_done_cnt", n_done - d0, 1);
        chk("ld_no_req", n_req - r0, 0);
        chk("ld_sb_left", sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        repeat (3) @(negedge in_Clock);
        chk("rst_sel", SEL, c_SEL_IDLE);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_req", {mem_req, mem_we, QUAD_inc, TOG_inc}, 0);
        chk("rst_quad", quad, 0);
        chk("rst_addr", {ART, ARG, AWT, AWG, A}, 0);
        in_Reset_n = 1'b1;
        @(negedge in_Clock);

        run_load(18'h2A5C3);
        run_load(18'h1_00FF);

        ack_rand = 1'b0; ack_fix = 1;
        run_scan(8'd4, 1'b0);
        ack_rand = 1'b1;
        run_scan(8'd5, 1'b0);
        ack_rand = 1'b0; ack_fix = 0;
        run_scan(8'd0, 1'b1);
        run_scan(8'd1, 1'b0);
        run_scan(8'd2, 1'b0);

        // Abort in WR_REQ of quad 2, then restart from the origin.
        begin
            int d0;
            ack_fix = 1;
            push_scan(8'd4);
            kick_scan(8'd4, 1'b0);
            for (int i = 0; i < 2000; i++) begin
                if (quad == 2'd2 && mem_req && mem_we) break;
                @(negedge in_Clock);
            end
            chk("abort_hit_wr_q2", {quad, mem_req, mem_we}, {2'd2, 1'b1, 1'b1});
            d0 = n_done;
            resp_abort = 1'b1;
            in_Reset_n = 1'b0;
            @(negedge in_Clock);
            chk("abort_busy", busy, 0);
            chk("abort_req", mem_req, 0);
            chk("abort_done", done, 0);
            chk("abort_sel", SEL, c_SEL_IDLE);
            chk("abort_quad", quad, 0);
            in_Reset_n = 1'b1;
            repeat (4) @(negedge in_Clock);
            chk("abort_no_done", n_done - d0, 0);
            resp_abort = 1'b0;
            sb.delete();
            ack_fix = 0;
            run_scan(8'd4, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        chk("global_timeout", 1, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
